// File: rtl/bist_pkg.sv
// Shared definitions for the BIST address sequencer: sequencer states and
// output-order mode codes.
package bist_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [1:0] MODE_LINEAR = 2'd0;
  localparam logic [1:0] MODE_GRAY   = 2'd1;
  localparam logic [1:0] MODE_COMPL  = 2'd2;

endpackage

// File: rtl/bist_addr_encode.sv
// Combinational map from the sweep counter to the issued address, selected
// by the latched output order; mode 11 falls through to linear.
module bist_addr_encode
  import bist_pkg::*;
#(
  parameter int A_WIDTH = 4
) (
  input  logic [A_WIDTH-1:0] cnt,
  input  logic [1:0]         mode,
  input  logic               phase,
  output logic [A_WIDTH-1:0] address
);

  always_comb begin
    address = cnt;
    case (mode)
      MODE_GRAY:  address = cnt ^ (cnt >> 1);
      MODE_COMPL: address = phase ? ~cnt : cnt;
      default:    address = cnt;
    endcase
  end

endmodule

// File: rtl/bist_addr_sequencer.sv
// BIST address sequencer: walks [lo_addr, hi_addr] up or down with a stride,
// issuing linear, Gray or complement ping-pong addresses to the memory mux.
module bist_addr_sequencer
  import bist_pkg::*;
#(
  parameter int A_WIDTH    = 4,
  parameter int STEP_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  up_down,
  input  logic [A_WIDTH-1:0]    lo_addr,
  input  logic [A_WIDTH-1:0]    hi_addr,
  input  logic [STEP_WIDTH-1:0] step,
  input  logic [1:0]            mode,
  input  logic                  hold,
  output logic [A_WIDTH-1:0]    address,
  output logic                  addr_valid,
  output logic                  last,
  output logic                  carry,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_RUN  = RUN;
  localparam logic [1:0] ST_DONE = DONE;

  // One spare bit above the wider operand so the sum never wraps and the
  // difference's top bit is a clean borrow flag.
  localparam int SW = ((STEP_WIDTH > A_WIDTH) ? STEP_WIDTH : A_WIDTH) + 1;

  logic [1:0]            state_reg;
  logic [A_WIDTH-1:0]    cnt_reg;
  logic                  phase_reg;
  logic                  up_reg;
  logic [A_WIDTH-1:0]    lo_reg;
  logic [A_WIDTH-1:0]    hi_reg;
  logic [STEP_WIDTH-1:0] step_reg;
  logic [1:0]            mode_reg;
  logic                  carry_reg;
  logic                  err_reg;

  logic [SW-1:0]         sum_next;
  logic [SW-1:0]         diff_next;
  logic                  final_idx;
  logic                  compl_mode;
  logic                  issue;
  logic                  last_beat;

  always_comb begin
    sum_next   = (SW)'(cnt_reg) + (SW)'(step_reg);
    diff_next  = (SW)'(cnt_reg) - (SW)'(step_reg);
    final_idx  = up_reg ? (sum_next > (SW)'(hi_reg))
                        : (diff_next[SW-1] || (diff_next < (SW)'(lo_reg)));
    compl_mode = (mode_reg == MODE_COMPL);
    issue      = (state_reg == ST_RUN) && !hold;
    last_beat  = final_idx && (!compl_mode || phase_reg);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      phase_reg <= 1'b0;
      up_reg    <= 1'b0;
      lo_reg    <= '0;
      hi_reg    <= '0;
      step_reg  <= '0;
      mode_reg  <= MODE_LINEAR;
      carry_reg <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      carry_reg <= 1'b0;
      case (state_reg)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            up_reg    <= up_down;
            lo_reg    <= lo_addr;
            hi_reg    <= hi_addr;
            step_reg  <= (step == '0) ? (STEP_WIDTH)'(1) : step;
            mode_reg  <= mode;
            phase_reg <= 1'b0;
            err_reg   <= 1'b0;
            if (lo_addr > hi_addr) begin
              state_reg <= ST_DONE;
              err_reg   <= 1'b1;
            end else begin
              state_reg <= ST_RUN;
              cnt_reg   <= up_down ? lo_addr : hi_addr;
            end
          end
        end
        ST_RUN: begin
          // The counter and phase stay put on the final beat so DONE keeps
          // presenting the last issued address.
          if (!hold) begin
            if (compl_mode && !phase_reg) begin
              phase_reg <= 1'b1;
            end else if (last_beat) begin
              state_reg <= ST_DONE;
              carry_reg <= 1'b1;
            end else begin
              cnt_reg   <= up_reg ? sum_next[A_WIDTH-1:0] : diff_next[A_WIDTH-1:0];
              phase_reg <= 1'b0;
            end
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  bist_addr_encode #(
    .A_WIDTH(A_WIDTH)
  ) u_encode (
    .cnt    (cnt_reg),
    .mode   (mode_reg),
    .phase  (phase_reg),
    .address(address)
  );

  assign addr_valid = issue;
  assign last       = issue && last_beat;
  assign carry      = carry_reg;
  assign busy       = (state_reg == ST_RUN);
  assign done       = (state_reg == ST_DONE);
  assign err        = err_reg;

endmodule

// File: tb/tb_bist_addr_sequencer.sv
// Self-checking bench for bist_addr_sequencer: expected address streams are
// queued before each start and popped as the DUT issues valid addresses.
module tb_bist_addr_sequencer;

  localparam int AW = 4;
  localparam int SWID = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            start = 1'b0;
  logic            up_down = 1'b1;
  logic [AW-1:0]   lo_addr = '0;
  logic [AW-1:0]   hi_addr = '0;
  logic [SWID-1:0] step = '0;
  logic [1:0]      mode = 2'd0;
  logic            hold = 1'b0;
  logic [AW-1:0]   address;
  logic            addr_valid;
  logic            last;
  logic            carry;
  logic            busy;
  logic            done;
  logic            err;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          last;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  bist_addr_sequencer #(
    .A_WIDTH(AW),
    .STEP_WIDTH(SWID)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .up_down(up_down),
    .lo_addr(lo_addr), .hi_addr(hi_addr), .step(step), .mode(mode),
    .hold(hold), .address(address), .addr_valid(addr_valid), .last(last),
    .carry(carry), .busy(busy), .done(done), .err(err)
  );

  // Scoreboard: every valid address must match the head of the queue.
  always @(negedge clk) begin
    if (addr_valid === 1'b1) begin
      exp_t e;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL scoreboard unexpected address got %0d (last %b) want none", address, last);
      end else begin
        e = exp_q.pop_front();
        if (address !== e.addr || last !== e.last) begin
          miscompares++;
          $display("FAIL scoreboard address got %0d last %b want %0d last %b", address, last, e.addr, e.last);
        end else begin
          $display("vector addr=%0d last=%b", address, last);
        end
      end
    end
  end

  function automatic void push(input int a, input bit l);
    exp_t e;
    e.addr = a[AW-1:0];
    e.last = l;
    exp_q.push_back(e);
  endfunction

  task automatic do_start(input bit ud, input int lo, input int hi, input int st, input int md);
    @(posedge clk); #1;
    up_down = ud;
    lo_addr = lo[AW-1:0];
    hi_addr = hi[AW-1:0];
    step    = st[SWID-1:0];
    mode    = md[1:0];
    start   = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk); #1;
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk); #1;
    vectors++;
    if ({address, addr_valid, last, carry, busy, done, err} !== {AW'(0), 6'b0}) begin
      miscompares++;
      $display("FAIL reset_state got addr=%0d v=%b l=%b c=%b b=%b d=%b e=%b want all 0",
               address, addr_valid, last, carry, busy, done, err);
    end
  endtask

  task automatic test_linear_full;
    bit ok;
    for (int i = 0; i < 16; i++) push(i, i == 15);
    do_start(1'b1, 0, 15, 1, 0);
    vectors++;
    if (addr_valid !== 1'b1 || address !== 4'd0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL start_latency got v=%b addr=%0d busy=%b want 1 0 1", addr_valid, address, busy);
    end
    wait_done(ok);
    vectors++;
    if (!ok || carry !== 1'b1) begin
      miscompares++;
      $display("FAIL linear_carry got done=%b carry=%b want 1 1", ok, carry);
    end
    @(negedge clk); #1;
    vectors++;
    if (carry !== 1'b0 || done !== 1'b1 || address !== 4'd15 || addr_valid !== 1'b0 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL linear_done got c=%b d=%b addr=%0d v=%b left=%0d want 0 1 15 0 0",
               carry, done, address, addr_valid, exp_q.size());
    end
  endtask

  task automatic test_down_stride;
    bit ok;
    push(12, 0); push(8, 0); push(4, 1);
    do_start(1'b0, 3, 12, 4, 0);
    wait_done(ok);
    vectors++;
    if (!ok || carry !== 1'b1 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL down_stride got done=%b carry=%b left=%0d want 1 1 0", ok, carry, exp_q.size());
    end
    @(negedge clk); #1;
    vectors++;
    if (carry !== 1'b0 || address !== 4'd4) begin
      miscompares++;
      $display("FAIL down_hold got carry=%b addr=%0d want 0 4", carry, address);
    end
  endtask

  task automatic test_step_zero;
    bit ok;
    push(2, 0); push(3, 0); push(4, 1);
    do_start(1'b1, 2, 4, 0, 0);
    wait_done(ok);
    vectors++;
    if (!ok || carry !== 1'b1 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL step_zero got done=%b carry=%b left=%0d want 1 1 0", ok, carry, exp_q.size());
    end
  endtask

  task automatic test_gray;
    bit ok;
    int g[8] = '{0, 1, 3, 2, 6, 7, 5, 4};
    for (int i = 0; i < 8; i++) push(g[i], i == 7);
    do_start(1'b1, 0, 7, 1, 1);
    wait_done(ok);
    vectors++;
    if (!ok || exp_q.size() != 0 || address !== 4'd4) begin
      miscompares++;
      $display("FAIL gray got done=%b left=%0d addr=%0d want 1 0 4", ok, exp_q.size(), address);
    end
  endtask

  task automatic test_compl;
    bit ok;
    push(0, 0); push(15, 0); push(1, 0); push(14, 1);
    do_start(1'b1, 0, 1, 1, 2);
    wait_done(ok);
    vectors++;
    if (!ok || carry !== 1'b1 || exp_q.size() != 0 || address !== 4'd14) begin
      miscompares++;
      $display("FAIL compl got done=%b carry=%b left=%0d addr=%0d want 1 1 0 14",
               ok, carry, exp_q.size(), address);
    end
  endtask

  task automatic test_hold;
    bit ok;
    bit seen;
    for (int i = 0; i < 16; i++) push(i, i == 15);
    do_start(1'b1, 0, 15, 1, 0);
    seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk); #1;
      if (addr_valid === 1'b1 && address === 4'd4) seen = 1'b1;
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL hold_reach got addr=%0d want 4 seen", address);
    end
    @(posedge clk); #1 hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      vectors++;
      if (address !== 4'd5 || addr_valid !== 1'b0 || last !== 1'b0 || busy !== 1'b1) begin
        miscompares++;
        $display("FAIL hold_freeze got addr=%0d v=%b l=%b b=%b want 5 0 0 1", address, addr_valid, last, busy);
      end
    end
    @(posedge clk); #1 hold = 1'b0;
    wait_done(ok);
    vectors++;
    if (!ok || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL hold_resume got done=%b left=%0d want 1 0", ok, exp_q.size());
    end
  endtask

  task automatic test_reset_mid;
    bit seen;
    bit carry_seen;
    for (int i = 0; i < 16; i++) push(i, i == 15);
    do_start(1'b1, 0, 15, 1, 0);
    seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk); #1;
      if (addr_valid === 1'b1 && address === 4'd6) seen = 1'b1;
    end
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    exp_q.delete();
    @(negedge clk); #1;
    vectors++;
    if (!seen || address !== 4'd0 || busy !== 1'b0 || addr_valid !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid got seen=%b addr=%0d b=%b v=%b d=%b want 1 0 0 0 0",
               seen, address, busy, addr_valid, done);
    end
    carry_seen = 1'b0;
    repeat (20) begin
      @(negedge clk); #1;
      if (carry !== 1'b0) carry_seen = 1'b1;
    end
    vectors++;
    if (carry_seen) begin
      miscompares++;
      $display("FAIL reset_mid_carry got pulse want none");
    end
  endtask

  task automatic test_err;
    bit ok;
    do_start(1'b1, 9, 2, 1, 0);
    @(negedge clk); #1;
    vectors++;
    if (err !== 1'b1 || done !== 1'b1 || carry !== 1'b0 || addr_valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL err_cfg got e=%b d=%b c=%b v=%b b=%b want 1 1 0 0 0", err, done, carry, addr_valid, busy);
    end
    repeat (5) @(negedge clk);
    #1;
    vectors++;
    if (err !== 1'b1 || done !== 1'b1) begin
      miscompares++;
      $display("FAIL err_sticky got e=%b d=%b want 1 1", err, done);
    end
    push(1, 0); push(3, 1);
    do_start(1'b1, 1, 3, 2, 0);
    vectors++;
    if (err !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL err_clear got e=%b d=%b b=%b want 0 0 1", err, done, busy);
    end
    wait_done(ok);
    vectors++;
    if (!ok || carry !== 1'b1 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL err_recover got done=%b carry=%b left=%0d want 1 1 0", ok, carry, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_linear_full();
    test_down_stride();
    test_step_zero();
    test_gray();
    test_compl();
    test_hold();
    test_reset_mid();
    test_err();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bist_addr_sequencer.md
Name: bist_addr_sequencer

Overview:
Parametrised BIST address sequencer, successor to the up/down address counter. Walks a programmable window [lo_addr, hi_addr] in either direction with a programmable stride. Offers linear, Gray-coded and complement ping-pong output orders for March-style memory tests. Sits between the BIST controller (start/done handshake) and the memory-under-test address mux.

Parameters:
A_WIDTH, 4, address width in bits
STEP_WIDTH, 4, width of the stride input

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high; one clock, synchronous active-high reset
start  input  1  one-cycle request to begin a sweep; sampled in IDLE or DONE only
up_down  input  1  1 = ascending (lo to hi), 0 = descending (hi to lo); latched on start
lo_addr  input  A_WIDTH  lower window bound, inclusive; latched on start
hi_addr  input  A_WIDTH  upper window bound, inclusive; latched on start
step  input  STEP_WIDTH  stride; 0 is treated as 1; latched on start
mode  input  2  00 linear, 01 Gray, 10 complement ping-pong, 11 treated as linear; latched on start
hold  input  1  pause; freezes sequencing while high
address  output  A_WIDTH  current test address
addr_valid  output  1  address is valid this cycle
last  output  1  high with the final valid address of the sweep
carry  output  1  one-cycle pulse on DONE entry (normal completion only)
busy  output  1  high in RUN
done  output  1  sticky high in DONE until next start or reset
err  output  1  configuration error (lo_addr > hi_addr); sticky until next start or reset

Behaviour:
- States: IDLE, RUN, DONE.
- Reset (any state, including mid-sweep): next state IDLE. address=0. addr_valid, last, carry, busy, done and err all 0. Internal counter and phase cleared.
- IDLE/DONE with start=1: latch the configuration and clear done and err.
  - If lo_addr > hi_addr: go to DONE with err=1 and done=1; carry=0; no valid address is ever issued.
  - Otherwise: go to RUN. Counter = lo_addr if ascending, hi_addr if descending.
- Start latency: start sampled at edge N; first addr_valid=1 in the cycle after edge N.
- start while in RUN is ignored.
- RUN, hold=0: addr_valid=1 and address=enc(cnt).
  - Ascending: next = cnt + step, computed in A_WIDTH+1 bits.
  - Descending: next = cnt - step, computed in A_WIDTH+1 bits with borrow.
  - Final index: ascending when cnt+step > hi_addr; descending when cnt-step < lo_addr or the subtraction borrows.
  - The counter never wraps, including full range 0 to 2^A_WIDTH-1 with step 1.
- Encoding enc():
  - linear: cnt.
  - Gray: cnt ^ (cnt >> 1).
  - complement: two beats per index, first cnt then ~cnt (phase bit toggles each beat). The counter advances only after the second beat.
- last=1 in the cycle with the final valid address: the final index in linear/Gray, or its second beat in complement mode. The next edge enters DONE.
- DONE entry cycle: carry=1 for exactly one cycle; done=1 sticky.
- In DONE, address holds the final issued address and addr_valid=0.
- RUN, hold=1: counter, phase and address frozen. addr_valid=0 and last=0. Sequencing resumes on the cycle after hold falls, with no address skipped or repeated.
- hold is ignored outside RUN.
- lo_addr == hi_addr: exactly one address (two beats in complement mode); last is high on it.
- busy = (state == RUN), including while held.

Decomposition:
- Shared package bist_pkg:
  - state enum (IDLE, RUN, DONE);
  - mode encoding constants (MODE_LINEAR, MODE_GRAY, MODE_COMPL).
- One natural sub-module: bist_addr_encode, a combinational map from (cnt, mode, phase) to address.
- Sequencer FSM, counter and bound checks stay in the top module.

Test Plan:
1. A_WIDTH=4, reset 2 cycles, then start with up, lo=0, hi=15, step=1, linear -> addresses 0..15 on 16 consecutive cycles; last with 15; carry pulse next cycle; done stays 1; address holds 15 with no wrap to 0.
2. start with down, lo=3, hi=12, step=4 -> addresses 12, 8, 4; last with 4; carry one cycle after; step=0 run with lo=2, hi=4 up -> 2, 3, 4.
3. start with up, lo=0, hi=7, Gray -> 0, 1, 3, 2, 6, 7, 5, 4; last with 4.
4. start with up, lo=0, hi=1, complement -> 0, 15, 1, 14; last only with 14.
5. Linear up 0..15, hold high 3 cycles while address=5 -> address stays 5 with addr_valid=0, then 6 follows. Separate run: reset asserted mid-sweep -> next cycle address=0, busy=0, carry never pulses.
6. start with lo=9, hi=2 -> err=1 and done=1 next cycle, addr_valid never 1, carry=0. A following valid start clears err and runs normally.
